// File: rtl/aes128_pkg.sv
// Shared AES column-mixing constants, FSM state type and GF(2^8) helpers.
package aes128_pkg;

    localparam logic [7:0] AES_POLY  = 8'h1B;
    localparam int         BYTE_W    = 8;
    localparam int         COL_W     = 32;
    localparam int         N_COL     = 4;
    localparam int         STATE_W   = 128;
    localparam int         COL_IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // GF(2^8) multiply, reducing with xtime after every shift so no carry escapes.
    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] acc;
        logic [BYTE_W-1:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < BYTE_W; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end else begin
                acc = acc;
            end
            x = {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
        end
        return acc;
    endfunction

    // Coefficient for a byte k rows below the output row (circulant matrix).
    function automatic logic [BYTE_W-1:0] mix_coef(input logic inv, input logic [1:0] k);
        logic [BYTE_W-1:0] c;
        case (k)
            2'd0:    c = inv ? 8'h0E : 8'h02;
            2'd1:    c = inv ? 8'h0B : 8'h03;
            2'd2:    c = inv ? 8'h0D : 8'h01;
            2'd3:    c = inv ? 8'h09 : 8'h01;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mixcol_word.sv
// Combinational single-column (Inv)MixColumns; inv_i=1 selects the inverse matrix.
module mixcol_word
    import aes128_pkg::*;
(
    input  logic [COL_W-1:0] col_i,
    input  logic             inv_i,
    output logic [COL_W-1:0] col_o
);

    // Each output row is the XOR of all four rows weighted by the rotated coefficients.
    always_comb begin
        col_o = '0;
        for (int r = 0; r < N_COL; r++) begin
            for (int j = 0; j < N_COL; j++) begin
                col_o[BYTE_W*r +: BYTE_W] = col_o[BYTE_W*r +: BYTE_W] ^
                    gf_mul(mix_coef(inv_i, 2'(j - r)), col_i[BYTE_W*j +: BYTE_W]);
            end
        end
    end

endmodule

// File: rtl/inv_mixcolumn.sv
// Iterative 128-bit InvMixColumns, one column per cycle; forward MixColumns on
// decrypt_i=0 when INV_MIXCOLUMN_FWD_MIXCOL_EN is defined.
module inv_mixcolumn
    import aes128_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               decrypt_i,
    input  logic [STATE_W-1:0] data_i,
    output logic [STATE_W-1:0] data_o,
    output logic               ready_o,
    output logic               busy_o
);

    state_t                 state_q, state_d;
    logic [COL_IDX_W-1:0]   col_q, col_d;
    logic [STATE_W-1:0]     in_q, in_d;
    logic [STATE_W-1:0]     res_q, res_d;
    logic [STATE_W-1:0]     out_q, out_d;
    logic                   ready_q, ready_d;
    logic                   accept_s;
    logic                   inv_mode_s;
    logic [COL_W-1:0]       word_in_s;
    logic [COL_W-1:0]       word_out_s;

    assign accept_s  = (state_q == IDLE) && start_i;
    assign word_in_s = in_q[{col_q, 5'd0} +: COL_W];

`ifdef INV_MIXCOLUMN_FWD_MIXCOL_EN
    logic dec_q, dec_d;

    // Mode is captured only when a request is accepted.
    always_comb begin
        dec_d = accept_s ? decrypt_i : dec_q;
    end

    // Mode register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q <= 1'b1;
        end else begin
            dec_q <= dec_d;
        end
    end

    assign inv_mode_s = dec_q;
`else
    logic unused_decrypt_s;
    assign unused_decrypt_s = decrypt_i;
    assign inv_mode_s       = 1'b1;
`endif

    mixcol_word u_mixcol_word (
        .col_i (word_in_s),
        .inv_i (inv_mode_s),
        .col_o (word_out_s)
    );

    // Next-state, column sequencing and result assembly.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        in_d    = in_q;
        res_d   = res_q;
        out_d   = out_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    in_d    = data_i;
                    col_d   = 2'd0;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                res_d[{col_q, 5'd0} +: COL_W] = word_out_s;
                col_d = col_q + 2'd1;
                // Last column bypasses res_q so the block completes on this edge.
                if (col_q == 2'd3) begin
                    out_d   = {word_out_s, res_q[3*COL_W-1:0]};
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = CALC;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and control registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            in_q    <= '0;
            res_q   <= '0;
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            in_q    <= in_d;
            res_q   <= res_d;
            out_q   <= out_d;
            ready_q <= ready_d;
        end
    end

    assign data_o  = out_q;
    assign ready_o = ready_q;
    assign busy_o  = (state_q == CALC);

endmodule

// File: tb/tb_inv_mixcolumn.sv
// Self-checking bench for inv_mixcolumn: timing scoreboard plus GF(2^8) reference model.
module tb_inv_mixcolumn;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         start_i   = 1'b0;
    logic         decrypt_i = 1'b1;
    logic [127:0] data_i    = 128'h0;
    logic [127:0] data_o;
    logic         ready_o;
    logic         busy_o;

    int tests = 0;
    int fails = 0;
    int edges = 0;

    localparam logic [127:0] ST_A  = 128'hC6C6C6C6_01010101_9D58DC9F_BCA14D8E;
    localparam logic [127:0] RES_A = 128'hC6C6C6C6_01010101_5C220AF2_455313DB;
    localparam logic [127:0] ST_B  = {4{32'hBCA14D8E}};
    localparam logic [127:0] RES_B = {4{32'h455313DB}};

    inv_mixcolumn dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .decrypt_i (decrypt_i),
        .data_i    (data_i),
        .data_o    (data_o),
        .ready_o   (ready_o),
        .busy_o    (busy_o)
    );

    always #5 clk = ~clk;

    // Carry-less product then polynomial long division by x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s, input logic dec);
        logic [7:0]   coef [4];
        logic [127:0] o;
        logic         use_inv;
`ifdef INV_MIXCOLUMN_FWD_MIXCOL_EN
        use_inv = dec;
`else
        use_inv = 1'b1;
`endif
        if (use_inv) coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else         coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = 128'h0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                for (int j = 0; j < 4; j++)
                    o[32*c + 8*r +: 8] = o[32*c + 8*r +: 8] ^
                        ref_mul(coef[(j - r + 4) % 4], s[32*c + 8*j +: 8]);
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) edges <= edges + 1;

    // Scoreboard: when a request is accepted and when its result must appear.
    logic         m_pend = 1'b0;
    int           m_due = 0;
    int           m_next_ok = 0;
    logic [127:0] m_res = 128'h0;
    logic [127:0] m_held = 128'h0;
    logic         m_ready = 1'b0;
    logic         m_busy = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pend    <= 1'b0;
            m_next_ok <= 0;
            m_held    <= 128'h0;
            m_ready   <= 1'b0;
            m_busy    <= 1'b0;
        end else begin
            m_ready <= m_pend && (edges == m_due);
            m_busy  <= (start_i && edges >= m_next_ok) || (m_pend && edges < m_due);
            if (m_pend && edges == m_due) begin
                m_held <= m_res;
                m_pend <= 1'b0;
            end
            if (start_i && edges >= m_next_ok) begin
                m_pend    <= 1'b1;
                m_due     <= edges + 4;
                m_next_ok <= edges + 5;
                m_res     <= ref_state(data_i, decrypt_i);
            end
        end
    end

    always @(negedge clk) begin
        if (edges > 0) begin
            chk("cyc_ready", {127'h0, ready_o}, {127'h0, m_ready});
            chk("cyc_busy",  {127'h0, busy_o},  {127'h0, m_busy});
            chk("cyc_data",  data_o, m_held);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_blk(input logic [127:0] d, input logic dec);
        data_i    = d;
        decrypt_i = dec;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        logic seen;
        seen = 1'b0;
        n    = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (ready_o) seen = 1'b1;
            else begin
                tick();
                n++;
            end
        end
        chk("ready_timeout", {127'h0, seen}, {127'h0, 1'b1});
    endtask

    initial begin
        int n;
        int pulses;

        chk("model_inv_pin", ref_state(ST_A, 1'b1), RES_A);
`ifdef INV_MIXCOLUMN_FWD_MIXCOL_EN
        chk("model_fwd_pin", ref_state({2{32'h4C31262D, 32'hD5D4D4D4}}, 1'b0),
            {2{32'hF8BD7E4D, 32'hD6D7D5D5}});
`endif

        repeat (3) tick();
        chk("reset_data", data_o, 128'h0);
        chk("reset_flags", {126'h0, ready_o, busy_o}, 128'h0);
        rst_n = 1'b1;
        tick();

        // Full state, latency of exactly 4 cycles after the sampling edge cycle.
        start_blk(ST_A, 1'b1);
        wait_ready(n);
        chk("latency", 128'(n), 128'd4);
        chk("full_state", data_o, RES_A);
        tick();

`ifdef INV_MIXCOLUMN_FWD_MIXCOL_EN
        start_blk({2{32'h4C31262D, 32'hD5D4D4D4}}, 1'b0);
        wait_ready(n);
        chk("fwd_cols", data_o, {2{32'hF8BD7E4D, 32'hD6D7D5D5}});
`else
        start_blk(ST_A, 1'b0);
        wait_ready(n);
        chk("decrypt_ignored", data_o, RES_A);
`endif
        tick();

        // Second start while busy is ignored.
        start_blk(ST_B, 1'b1);
        tick();
        start_blk(ST_A, 1'b1);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            if (ready_o) pulses++;
            tick();
        end
        chk("busy_start_pulses", 128'(pulses), 128'd1);
        chk("busy_start_data", data_o, RES_B);

        // Back-to-back: start in the ready cycle.
        start_blk(ST_A, 1'b1);
        wait_ready(n);
        chk("b2b_first", data_o, RES_A);
        start_blk(ST_B, 1'b1);
        wait_ready(n);
        chk("b2b_latency", 128'(n), 128'd4);
        chk("b2b_second", data_o, RES_B);
        tick();

        // Reset in the 3rd CALC cycle aborts the block.
        start_blk(ST_A, 1'b1);
        tick();
        tick();
        rst_n = 1'b0;
        #2;
        chk("abort_data", data_o, 128'h0);
        chk("abort_flags", {126'h0, ready_o, busy_o}, 128'h0);
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            if (ready_o) pulses++;
            tick();
        end
        chk("abort_no_ready", 128'(pulses), 128'd0);
        start_blk(ST_B, 1'b1);
        wait_ready(n);
        chk("after_abort", data_o, RES_B);
        tick();

        // Random traffic, including starts during busy and decrypt_i toggling.
        for (int i = 0; i < 400; i++) begin
            start_i   = ($urandom_range(0, 3) == 0);
            decrypt_i = $urandom_range(0, 1) == 1;
            data_i    = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        start_i = 1'b0;
        repeat (8) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
